alu_multicycle_unit: RTL
========================

ALU_MULTICYCLE_UNIT -- requirements
Module: alu_multicycle_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 16: datapath and result width.
REQ-002 SHALL have clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-003 SHALL have reset, input, 1 bit: reset, synchronous, active-high.
REQ-004 SHALL have start, input, 1 bit: request a new operation; sampled only in IDLE.
REQ-005 SHALL have op, input, 2 bits: 00 MUL, 01 SLL, 10 SRL, 11 SRA.
REQ-006 SHALL have a, input, WIDTH bits: signed operand A, the multiplicand or shift source.
REQ-007 SHALL have b, input, WIDTH bits: signed operand B, the multiplier; for shifts the amount is b[3:0].
REQ-008 SHALL have busy, output, 1 bit: high in RUN and DONE.
REQ-009 SHALL have alu_result, output, WIDTH bits: signed result driving the ALUOut register data input.
REQ-010 SHALL have alu_out_write, output, 1 bit: one-cycle write strobe to the ALUOut register.

Function
REQ-011 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-012 IDLE with start=1 SHALL latch a, b and op in the same edge and load the iteration counter (MUL: 16; shifts: b[3:0]).
REQ-013 The IDLE-to-next-state transition SHALL go to RUN if the loaded count is nonzero, else directly to DONE.
REQ-014 RUN SHALL perform exactly one iteration per cycle and decrement the counter; on the last iteration it SHALL go to DONE.
REQ-015 MUL SHALL use radix-2 shift-add; the result SHALL be the low WIDTH bits of a*b (two's complement wrap, no overflow flag).
REQ-016 SLL SHALL shift left one bit per iteration with zero fill.
REQ-017 SRL SHALL shift right one bit per iteration with zero fill.
REQ-018 SRA SHALL shift right one bit per iteration with sign fill.
REQ-019 b[15:4] SHALL be ignored for shifts.
REQ-020 DONE SHALL last exactly one cycle; in it alu_out_write=1 and alu_result holds the final value, then the FSM returns to IDLE.
REQ-021 Latency from the start-sampling edge to the alu_out_write cycle SHALL be 17 cycles for MUL and b[3:0]+1 cycles for shifts (1 for a zero shift amount).
REQ-022 alu_out_write SHALL be 0 in every cycle other than DONE.
REQ-023 alu_result SHALL update only on entry to DONE and SHALL hold its value otherwise, including while IDLE and during RUN.
REQ-024 start in RUN or DONE SHALL be ignored, with no queuing; the earliest next acceptance is the first IDLE cycle after DONE.
REQ-025 Changes on a, b and op after acceptance SHALL NOT affect the operation in flight.

Reset
REQ-026 reset SHALL force the state to IDLE and the counter and internal operand/accumulator registers to 0.
REQ-027 reset SHALL force busy=0, alu_out_write=0 and alu_result=0 from the next edge.
REQ-028 reset asserted in RUN or DONE SHALL abort the operation with no alu_out_write pulse, including when coincident with DONE.
REQ-029 When reset and start are both high, reset SHALL win and start SHALL be ignored.

Structure
REQ-030 Shared package alu_mc_pkg SHALL hold the op encoding constants, FSM state encoding, WIDTH default and MUL iteration count (16).
REQ-031 The block SHALL be a single module with no sub-module.
REQ-032 Datapath SHALL consist of an operand shift register, an accumulator and a 5-bit counter.
REQ-033 Outputs SHALL be registered.

Verification
REQ-034 MUL a=7, b=-3 -> alu_result=0xFFEB (-21), alu_out_write high for one cycle exactly 17 cycles after start; busy high for those 17 cycles.
REQ-035 MUL a=0x0100, b=0x0100 -> alu_result=0x0000 (wrap); MUL a=-1, b=-1 -> 0x0001.
REQ-036 SRA a=0x8000, b=4 -> 0xF800 at latency 5; SRL same operands -> 0x0800; SLL a=0x0001, b=15 -> 0x8000 at latency 16.
REQ-037 SLL a=0x1234, b=0x0010 (amount 0) -> 0x1234, strobe at latency 1, no RUN cycles.
REQ-038 start pulsed during RUN with different operands -> ignored; original result written once; back-to-back start on the first IDLE cycle is accepted.
REQ-039 reset at RUN cycle 5 of a MUL -> busy=0 next cycle, no strobe, alu_result=0; the next start then completes normally.

Source files
------------

// File: rtl/alu_mc_pkg.sv
// Shared constants for the multi-cycle ALU: op encoding, FSM state encoding,
// default datapath width and the iteration-count helper.
package alu_mc_pkg;

    localparam int          ALU_WIDTH = 16;
    localparam logic [4:0]  MUL_ITERS = 5'd16;

    localparam logic [1:0]  OP_MUL = 2'b00;
    localparam logic [1:0]  OP_SLL = 2'b01;
    localparam logic [1:0]  OP_SRL = 2'b10;
    localparam logic [1:0]  OP_SRA = 2'b11;

    localparam logic [1:0]  S_IDLE = 2'd0;
    localparam logic [1:0]  S_RUN  = 2'd1;
    localparam logic [1:0]  S_DONE = 2'd2;

    // Shifts run one iteration per bit of the 4-bit amount; MUL always runs the full count.
    function automatic logic [4:0] iter_count(input logic [1:0] op, input logic [3:0] amt);
        return (op == OP_MUL) ? MUL_ITERS : {1'b0, amt};
    endfunction

endpackage

// File: rtl/alu_multicycle_unit.sv
// Multi-cycle ALU: radix-2 shift-add multiply and one-bit-per-cycle shifts,
// with a registered result and a one-cycle write strobe for the ALUOut register.
module alu_multicycle_unit
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic [WIDTH-1:0] alu_result,
    output logic             alu_out_write
);

    logic [1:0]       state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [4:0]       cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             wr_q, wr_d;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        res_d   = res_q;
        wr_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d   = op;
                    opa_d  = a;
                    opb_d  = b;
                    acc_d  = '0;
                    cnt_d  = iter_count(op, b[3:0]);
                    busy_d = 1'b1;
                    // A zero shift amount has nothing to iterate: the source is the result.
                    if (cnt_d == 5'd0) begin
                        state_d = S_DONE;
                        wr_d    = 1'b1;
                        res_d   = a;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                case (op_q)
                    OP_MUL: begin
                        if (opb_q[0]) acc_d = acc_q + opa_q;
                        opa_d = opa_q << 1;
                        opb_d = opb_q >> 1;
                    end
                    OP_SLL:  opa_d = opa_q << 1;
                    OP_SRL:  opa_d = opa_q >> 1;
                    default: opa_d = {opa_q[WIDTH-1], opa_q[WIDTH-1:1]};
                endcase
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    state_d = S_DONE;
                    wr_d    = 1'b1;
                    res_d   = (op_q == OP_MUL) ? acc_d : opa_d;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            res_q   <= '0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            res_q   <= res_d;
            wr_q    <= wr_d;
        end
    end

    assign busy          = busy_q;
    assign alu_result    = res_q;
    assign alu_out_write = wr_q;

endmodule
